// File: rtl/nios_pio_pkg.sv
// ----------------------------------------------------------------
// nios_pio_pkg: register map and STATUS bit positions shared by the Nios PIOs
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd3;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_EN_BIT    = 1;

endpackage

`default_nettype wire

// File: rtl/nios_pio_blink_timer.sv
// ----------------------------------------------------------------
// nios_pio_blink_timer: reloading down-counter that toggles a blink phase
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module nios_pio_blink_timer
  import nios_pio_pkg::*;
#(
  parameter int             DIV_W          = 24,
  parameter logic [DIV_W-1:0] DEFAULT_PERIOD = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] i_period,     // new value when i_period_wr, else current PERIOD
  input  logic             i_period_wr,
  output logic             o_phase
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_phase;

  // A PERIOD write restarts the interval even if the counter expires on that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= DEFAULT_PERIOD;
      r_phase <= 1'b0;
    end else if (i_period_wr) begin
      r_cnt   <= i_period;
      r_phase <= 1'b0;
    end else if (i_period == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt   <= i_period;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - DIV_W'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

`default_nettype wire

// File: rtl/nios_led_pio_out.sv
// ----------------------------------------------------------------
// nios_led_pio_out: Avalon-MM LED output PIO with atomic set/clear and blink
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module nios_led_pio_out
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH          = 4,
  parameter int               DIV_W          = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [DIV_W-1:0] DEFAULT_PERIOD = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [DIV_W-1:0] r_period;
  logic [31:0]      r_readdata;
  logic [WIDTH-1:0] r_out;

  logic             w_wr;
  logic             w_period_wr;
  logic [DIV_W-1:0] w_period_in;
  logic             w_phase;
  logic [WIDTH-1:0] w_wdata;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wr        = chipselect & ~write_n;
  assign w_period_wr = w_wr && (address == ADDR_PERIOD);
  assign w_period_in = w_period_wr ? writedata[DIV_W-1:0] : r_period;
  assign w_wdata     = writedata[WIDTH-1:0];
  assign w_unused    = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VALUE;
      r_mask   <= '0;
      r_period <= DEFAULT_PERIOD;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data   <= w_wdata;
        ADDR_MASK:     r_mask   <= w_wdata;
        ADDR_PERIOD:   r_period <= writedata[DIV_W-1:0];
        ADDR_OUTSET:   r_data   <= r_data | w_wdata;
        ADDR_OUTCLEAR: r_data   <= r_data & ~w_wdata;
        default:       ;
      endcase
    end
  end

  nios_pio_blink_timer #(
    .DIV_W          (DIV_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_blink (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_period    (w_period_in),
    .i_period_wr (w_period_wr),
    .o_phase     (w_phase)
  );

  // Reads sample pre-edge contents, so a same-cycle write shows up one read later.
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:   w_rdata[WIDTH-1:0] = r_data;
      ADDR_MASK:   w_rdata[WIDTH-1:0] = r_mask;
      ADDR_PERIOD: w_rdata[DIV_W-1:0] = r_period;
      ADDR_STATUS: begin
        w_rdata[STATUS_PHASE_BIT] = w_phase;
        w_rdata[STATUS_EN_BIT]    = |r_period;
      end
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_out      <= RESET_VALUE;
    end else begin
      r_readdata <= w_rdata;
      r_out      <= r_data ^ (r_mask & {WIDTH{w_phase}});
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out;

endmodule

`default_nettype wire

// File: tb/tb_nios_led_pio_out.sv
// ----------------------------------------------------------------
// tb_nios_led_pio_out: directed stimulus with a cycle-tagged scoreboard
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_nios_led_pio_out;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         chipselect;
  logic [2:0]   address;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;

  always #5 clk = ~clk;

  nios_led_pio_out #(
    .WIDTH          (W),
    .DIV_W          (24),
    .RESET_VALUE    (4'hA),
    .DEFAULT_PERIOD (24'd0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          is_port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   fin_req = 1'b0;
  bit   fin_done = 1'b0;

  task automatic push(input int due, input bit is_port, input logic [31:0] exp, input string name);
    exp_t e;
    e.due = due; e.is_port = is_port; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: every expectation is compared at the falling edge of the cycle it names.
  always @(negedge clk) begin : mon
    int          i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        act = sb[i].is_port ? 32'(out_port) : readdata;
        checks++;
        if (sb[i].due < cyc || act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d: got 0x%08h want 0x%08h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
    if (fin_req && !fin_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      fin_done = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    address = a;
    push(cyc + 1, 1'b0, e, n);
    @(posedge clk); #1;
  endtask

  // Called right after a PERIOD write edge with address on STATUS: phase is 1
  // during the odd-numbered (p+1)-cycle intervals, seen one cycle later.
  task automatic blink_exp(input int p, input int port_n, input int rd_n, input string n);
    bit lit;
    for (int k = 1; k <= port_n; k++) begin
      lit = (((k - 1) / (p + 1)) % 2) == 1;
      push(cyc + k, 1'b1, lit ? 32'h1 : 32'h0, {n, "_port"});
      if (k <= rd_n) push(cyc + k, 1'b0, lit ? 32'h3 : 32'h2, {n, "_status"});
    end
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    idle(1);
    push(cyc, 1'b1, 32'hA, "rst_port");
    push(cyc, 1'b0, 32'h0, "rst_readdata");
    idle(1);
    reset_n = 1'b1;

    rd(3'd0, 32'hA, "rd_data_reset");

    wr(3'd0, 32'h5); push(cyc + 1, 1'b1, 32'h5, "data_wr_port");
    wr(3'd3, 32'h2); push(cyc + 1, 1'b1, 32'h7, "outset_port");
    wr(3'd4, 32'h4); push(cyc + 1, 1'b1, 32'h3, "outclear_port");
    rd(3'd3, 32'h0, "rd_outset");
    rd(3'd4, 32'h0, "rd_outclear");
    rd(3'd0, 32'h3, "rd_data_after_setclr");

    wr(3'd1, 32'h1);
    wr(3'd0, 32'h0);
    wr(3'd2, 32'd3);
    address = 3'd5;
    blink_exp(3, 11, 10, "blink_p3");
    idle(10);

    wr(3'd2, 32'd1);
    address = 3'd5;
    blink_exp(1, 8, 8, "blink_p1");
    idle(8);

    wr(3'd2, 32'd0);
    address = 3'd5;
    for (int k = 1; k <= 6; k++) begin
      push(cyc + k, 1'b1, 32'h0, "p0_port");
      push(cyc + k, 1'b0, 32'h0, "p0_status");
    end
    idle(6);

    wr(3'd0, 32'hFFFF_FFFF);
    push(cyc + 1, 1'b1, 32'hF, "wide_port");
    rd(3'd0, 32'hF, "rd_data_wide");
    wr(3'd6, 32'h0);
    rd(3'd0, 32'hF, "rd_data_after_a6");
    rd(3'd1, 32'h1, "rd_mask_after_a6");
    rd(3'd2, 32'h0, "rd_period_after_a6");
    rd(3'd6, 32'h0, "rd_a6");
    rd(3'd7, 32'h0, "rd_a7");

    wr(3'd0, 32'h0);
    wr(3'd2, 32'd2);
    address = 3'd5;
    blink_exp(2, 4, 4, "blink_p2");
    idle(5);
    #2;
    reset_n = 1'b0;
    push(cyc, 1'b1, 32'hA, "async_rst_port");
    push(cyc, 1'b0, 32'h0, "async_rst_readdata");
    repeat (2) begin
      @(posedge clk); #1;
      push(cyc, 1'b1, 32'hA, "hold_rst_port");
      push(cyc, 1'b0, 32'h0, "hold_rst_readdata");
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      push(cyc + k, 1'b1, 32'hA, "post_rst_port");
      push(cyc + k, 1'b0, 32'h0, "post_rst_status");
    end
    idle(6);
    rd(3'd0, 32'hA, "rd_data_post_rst");
    rd(3'd1, 32'h0, "rd_mask_post_rst");
    rd(3'd2, 32'h0, "rd_period_post_rst");

    idle(2);
    fin_req = 1'b1;
    idle(2);
    if (!fin_done) $display("FAIL monitor_done: got 0 want 1");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
